// File: rtl/uart_pkg.sv
// Shared UART definitions: ASCII constants, line-buffer state encoding and
// baud timing used by the receiver, transmitter and line buffer.
package uart_pkg;

  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_CR = 8'h0D;

  localparam logic ST_FILL  = 1'b0;
  localparam logic ST_DRAIN = 1'b1;

  typedef enum logic {
    S_FILL  = ST_FILL,
    S_DRAIN = ST_DRAIN
  } line_state_e;

  // 12 MHz board clock at 115200 baud: ~104 clk per bit, ~1042 per 10-bit frame.
  localparam int unsigned CLK_HZ    = 12_000_000;
  localparam int unsigned BAUD      = 115_200;
  localparam int unsigned BAUD_DIV  = CLK_HZ / BAUD;
  localparam int unsigned BAUD_HALF = BAUD_DIV / 2;

endpackage

// File: rtl/uart_rx_line_buf.sv
// Collects received bytes into a line and replays the line as a valid/ready
// byte stream once a terminator arrives or the buffer fills.
module uart_rx_line_buf
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH    = 32,
  parameter logic [7:0]  TERM     = CHAR_LF,
  parameter bit          STRIP_CR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_strobe,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [$clog2(DEPTH+1)-1:0] line_len,
  output logic                       line_trunc,
  output logic [7:0]                 drop_cnt
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [7:0]    mem_q [DEPTH];
  line_state_e   state_q;
  logic [CW-1:0] wr_cnt_q;
  logic [CW-1:0] rd_idx_q;
  logic [CW-1:0] line_len_q;
  logic          line_trunc_q;
  logic          out_valid_q;
  logic          out_last_q;
  logic [7:0]    out_data_q;
  logic [7:0]    drop_cnt_q;

  logic          is_strip;
  logic          is_term;
  logic          store_en;
  logic [CW-1:0] wr_cnt_d;
  logic [CW-1:0] rd_idx_d;
  logic [CW-1:0] last_idx;

  // NOTE: every signal gets a value at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    is_strip = STRIP_CR && (rx_byte == CHAR_CR);
    is_term  = (rx_byte == TERM);
    store_en = (state_q == S_FILL) && rx_strobe && !is_strip && !is_term;
    wr_cnt_d = wr_cnt_q + ONE_C;
    rd_idx_d = rd_idx_q + ONE_C;
    last_idx = line_len_q - ONE_C;
  end

  // NOTE: the line buffer is deliberately not reset; entries are only read
  // after being written for the current line, so reset would add no value.
  always_ff @(posedge clk) begin
    if (store_en) begin
      mem_q[wr_cnt_q[AW-1:0]] <= rx_byte;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FILL;
      wr_cnt_q     <= '0;
      rd_idx_q     <= '0;
      line_len_q   <= '0;
      line_trunc_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= 8'h00;
      drop_cnt_q   <= 8'h00;
    end else begin
      // Any byte arriving while a line is being drained is lost.
      if ((state_q == S_DRAIN) && rx_strobe && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'h01;
      end

      case (state_q)
        S_FILL: begin
          if (rx_strobe && !is_strip) begin
            if (is_term) begin
              if (wr_cnt_q != '0) begin
                state_q      <= S_DRAIN;
                line_len_q   <= wr_cnt_q;
                line_trunc_q <= 1'b0;
                rd_idx_q     <= '0;
                out_valid_q  <= 1'b1;
                out_data_q   <= mem_q[0];
                out_last_q   <= (wr_cnt_q == ONE_C);
              end
            end else begin
              wr_cnt_q <= wr_cnt_d;
              // DEPTH >= 2, so a full line never ends on its first byte.
              if (wr_cnt_d == DEPTH_C) begin
                state_q      <= S_DRAIN;
                line_len_q   <= DEPTH_C;
                line_trunc_q <= 1'b1;
                rd_idx_q     <= '0;
                out_valid_q  <= 1'b1;
                out_data_q   <= mem_q[0];
                out_last_q   <= 1'b0;
              end
            end
          end
        end

        S_DRAIN: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q      <= S_FILL;
              wr_cnt_q     <= '0;
              rd_idx_q     <= '0;
              line_len_q   <= '0;
              line_trunc_q <= 1'b0;
              out_valid_q  <= 1'b0;
              out_last_q   <= 1'b0;
              out_data_q   <= 8'h00;
            end else begin
              rd_idx_q   <= rd_idx_d;
              out_data_q <= mem_q[rd_idx_d[AW-1:0]];
              out_last_q <= (rd_idx_d == last_idx);
            end
          end
        end

        default: state_q <= S_FILL;
      endcase
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_last   = out_last_q;
  assign line_len   = line_len_q;
  assign line_trunc = line_trunc_q;
  assign drop_cnt   = drop_cnt_q;

endmodule
